// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-multiply engine. It provides the FSM state
// type, the dimension field width, the default datapath sizes and the
// dimension-legality helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package matmul_pkg;

  localparam int DIM_W       = 4;
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_MAX_DIM = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MAC,
    ST_EMIT
  } state_t;

  function automatic logic dim_in_range(input logic [DIM_W-1:0] d, input int max_dim);
    return (int'(d) >= 1) && (int'(d) <= max_dim);
  endfunction

  // A (r1 x c1) times B (r2 x c2) needs c1 == r2 and every extent in 1..max_dim.
  function automatic logic dims_legal(input logic [DIM_W-1:0] r1, input logic [DIM_W-1:0] c1,
                                      input logic [DIM_W-1:0] r2, input logic [DIM_W-1:0] c2,
                                      input int max_dim);
    return (c1 == r2) && dim_in_range(r1, max_dim) && dim_in_range(c1, max_dim) &&
           dim_in_range(r2, max_dim) && dim_in_range(c2, max_dim);
  endfunction

endpackage

// File: rtl/matmul_if.sv
// -----------------------------------------------------------------------------
// matmul_if
// Bundles the engine's two synchronous operand read ports and the result stream.
//   a_rd_row/a_rd_col -> a_rd_data : A storage read, data one cycle after address
//   b_rd_row/b_rd_col -> b_rd_data : B storage read, data one cycle after address
//   c_valid/c_ready               : result handshake
//   c_data/c_row/c_col/c_last     : result element payload
// Modports: master = engine side, slave = storage + downstream side.
// -----------------------------------------------------------------------------
interface matmul_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
);
  logic [matmul_pkg::DIM_W-1:0] a_rd_row;
  logic [matmul_pkg::DIM_W-1:0] a_rd_col;
  logic [DATA_W-1:0]            a_rd_data;
  logic [matmul_pkg::DIM_W-1:0] b_rd_row;
  logic [matmul_pkg::DIM_W-1:0] b_rd_col;
  logic [DATA_W-1:0]            b_rd_data;
  logic                         c_valid;
  logic                         c_ready;
  logic [ACC_W-1:0]             c_data;
  logic [matmul_pkg::DIM_W-1:0] c_row;
  logic [matmul_pkg::DIM_W-1:0] c_col;
  logic                         c_last;

  modport master (
    output a_rd_row, a_rd_col, b_rd_row, b_rd_col,
    output c_valid, c_data, c_row, c_col, c_last,
    input  a_rd_data, b_rd_data, c_ready
  );

  modport slave (
    input  a_rd_row, a_rd_col, b_rd_row, b_rd_col,
    input  c_valid, c_data, c_row, c_col, c_last,
    output a_rd_data, b_rd_data, c_ready
  );
endinterface

// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Unsigned multiply-accumulate. It adds i_a*i_b to the accumulator on each
// cycle in which i_vld_p1 is high. i_clear zeroes the accumulator and takes
// priority over i_vld_p1.
// Ports: i_clk, i_rst (async, active-high), i_clear, i_vld_p1, i_a, i_b, o_acc.
// Build option: define ACC_SAT_EN to clamp the accumulator at 2^ACC_W-1.
// Without it, the accumulator wraps modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module mac_unit #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_vld_p1,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc
);

  logic [2*DATA_W-1:0] w_prod_p1;
  logic [ACC_W-1:0]    r_acc;

  // Operands and accumulator are non-negative, so an overflow always shows up
  // as a carry out of the top bit.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] prod);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {1'b0, prod};
`ifdef ACC_SAT_EN
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    return sum[ACC_W-1:0];
`endif
  endfunction

  assign w_prod_p1 = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);

  // ---- stage p1: accumulate product of the operands read last cycle ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_acc <= '0;
    else if (i_clear)  r_acc <= '0;
    else if (i_vld_p1) r_acc <= acc_add(r_acc, ACC_W'(w_prod_p1));
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/matmul_engine.sv
// -----------------------------------------------------------------------------
// matmul_engine
// Computes C = A x B with one multiply-accumulate per cycle. It reads operands
// through two synchronous read ports and streams C in row-major order.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           begin a multiply (ignored unless idle)
//   i_r1,i_c1         A rows/cols; i_r2,i_c2 B rows/cols (latched on start)
//   o_busy            high outside IDLE
//   o_dim_err         one-cycle pulse when the latched dimensions are illegal
//   m_if (master)     operand read ports + c_* result stream
// Build option: ACC_SAT_EN (handled inside mac_unit) selects a saturating
// accumulator instead of a wrapping one.
// -----------------------------------------------------------------------------
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DIM_W-1:0] i_r1,
  input  logic [DIM_W-1:0] i_c1,
  input  logic [DIM_W-1:0] i_r2,
  input  logic [DIM_W-1:0] i_c2,
  output logic             o_busy,
  output logic             o_dim_err,
  matmul_if.master         m_if
);

  state_t           r_state, w_next;
  logic [DIM_W-1:0] r_r1, r_c1, r_r2, r_c2;
  logic [DIM_W-1:0] r_i, r_j, r_k;
  logic             w_clear, w_vld_p1, w_hs, w_last;
  logic [ACC_W-1:0] w_acc;

  assign w_hs   = (r_state == ST_EMIT) && m_if.c_ready;
  assign w_last = (r_state == ST_EMIT) && (r_i == r_r1 - DIM_W'(1)) && (r_j == r_c2 - DIM_W'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_dim_err = 1'b0;
    w_clear   = 1'b0;
    w_vld_p1  = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_CHECK;
      ST_CHECK: begin
        if (dims_legal(r_r1, r_c1, r_r2, r_c2, MAX_DIM)) begin
          w_clear = 1'b1;
          w_next  = ST_MAC;
        end else begin
          o_dim_err = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_MAC: begin
        // The address issued at k arrives at k+1, so cycle 0 has no data and
        // the last product lands on k == C1.
        w_vld_p1 = (r_k != '0);
        if (r_k == r_c1) w_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (w_hs) begin
          if (w_last) begin
            w_next = ST_IDLE;
          end else begin
            w_clear = 1'b1;
            w_next  = ST_MAC;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ---- stage p0: dimension latch, element/index counters, read addresses ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_r1 <= '0;
      r_c1 <= '0;
      r_r2 <= '0;
      r_c2 <= '0;
      r_i  <= '0;
      r_j  <= '0;
      r_k  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_r1 <= i_r1;
            r_c1 <= i_c1;
            r_r2 <= i_r2;
            r_c2 <= i_c2;
          end
        end
        ST_CHECK: begin
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
        end
        ST_MAC: if (r_k != r_c1) r_k <= r_k + DIM_W'(1);
        ST_EMIT: begin
          if (w_hs) begin
            r_k <= '0;
            if (w_last) begin
              r_i <= '0;
              r_j <= '0;
            end else if (r_j == r_c2 - DIM_W'(1)) begin
              r_j <= '0;
              r_i <= r_i + DIM_W'(1);
            end else begin
              r_j <= r_j + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_clear),
    .i_vld_p1(w_vld_p1),
    .i_a     (m_if.a_rd_data),
    .i_b     (m_if.b_rd_data),
    .o_acc   (w_acc)
  );

  assign m_if.a_rd_row = r_i;
  assign m_if.a_rd_col = r_k;
  assign m_if.b_rd_row = r_k;
  assign m_if.b_rd_col = r_j;
  assign m_if.c_valid  = (r_state == ST_EMIT);
  assign m_if.c_data   = w_acc;
  assign m_if.c_row    = r_i;
  assign m_if.c_col    = r_j;
  assign m_if.c_last   = w_last;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_matmul_engine.sv
// -----------------------------------------------------------------------------
// tb_matmul_engine
// Testbench for matmul_engine. It runs a 16-bit instance and an 8-bit
// accumulator instance, both fed from shared operand memories.
// -----------------------------------------------------------------------------
module tb_matmul_engine;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        last;
  } elem_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start8;
  logic [3:0] r1, c1, r2, c2;
  logic       busy, dim_err, busy8, dim_err8;

  logic [3:0] mem_a [16][16];
  logic [3:0] mem_b [16][16];

  elem_t exp_q[$];
  elem_t got_q[$];
  int    got_t[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  matmul_if #(.DATA_W(4), .ACC_W(16)) mif ();
  matmul_if #(.DATA_W(4), .ACC_W(8))  mif8 ();

  matmul_engine #(.DATA_W(4), .MAX_DIM(3), .ACC_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_r1(r1), .i_c1(c1), .i_r2(r2), .i_c2(c2),
    .o_busy(busy), .o_dim_err(dim_err), .m_if(mif)
  );

  matmul_engine #(.DATA_W(4), .MAX_DIM(3), .ACC_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8),
    .i_r1(r1), .i_c1(c1), .i_r2(r2), .i_c2(c2),
    .o_busy(busy8), .o_dim_err(dim_err8), .m_if(mif8)
  );

  always #5 clk = ~clk;

  // Synchronous operand storage: data one cycle after address.
  always_ff @(posedge clk) begin
    mif.a_rd_data  <= mem_a[mif.a_rd_row][mif.a_rd_col];
    mif.b_rd_data  <= mem_b[mif.b_rd_row][mif.b_rd_col];
    mif8.a_rd_data <= mem_a[mif8.a_rd_row][mif8.a_rd_col];
    mif8.b_rd_data <= mem_b[mif8.b_rd_row][mif8.b_rd_col];
  end

  task automatic clear_mem();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        mem_a[x][y] = 4'd0;
        mem_b[x][y] = 4'd0;
      end
  endtask

  task automatic fill_mem(input int ra, input int ca, input int cb, input int va, input int vb);
    clear_mem();
    for (int x = 0; x < ra; x++) for (int y = 0; y < ca; y++) mem_a[x][y] = 4'(va);
    for (int x = 0; x < ca; x++) for (int y = 0; y < cb; y++) mem_b[x][y] = 4'(vb);
  endtask

  // Reference matrix product into the expected-result queue.
  task automatic model(input int mr1, input int mc1, input int mc2);
    elem_t e;
    exp_q.delete();
    for (int i = 0; i < mr1; i++)
      for (int j = 0; j < mc2; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < mc1; k++) s += int'(mem_a[i][k]) * int'(mem_b[k][j]);
        e.data = 16'(s);
        e.row  = 4'(i);
        e.col  = 4'(j);
        e.last = (i == mr1 - 1) && (j == mc2 - 1);
        exp_q.push_back(e);
      end
  endtask

  // Pulse start with the given dims, then scramble the dim inputs; returns at the negedge after start.
  task automatic do_start(input int a, input int b, input int c, input int d, input bit use8);
    @(negedge clk);
    r1 = 4'(a); c1 = 4'(b); r2 = 4'(c); c2 = 4'(d);
    if (use8) start8 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    r1 = 4'hF; c1 = 4'hE; r2 = 4'hD; c2 = 4'h0;
  endtask

  // Record accepted elements of the 16-bit instance with their negedge index.
  task automatic collect(input int n, input int maxcyc);
    int cyc;
    elem_t o;
    cyc = 0;
    got_q.delete();
    got_t.delete();
    while (got_q.size() < n && cyc < maxcyc) begin
      @(negedge clk);
      cyc++;
      if (mif.c_valid && mif.c_ready) begin
        o = {mif.c_data, mif.c_row, mif.c_col, mif.c_last};
        got_q.push_back(o);
        got_t.push_back(cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    r1 = '0; c1 = '0; r2 = '0; c2 = '0;
    mif.c_ready = 1'b0; mif8.c_ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    n_tests++; if ({busy, dim_err, mif.c_valid, mif.c_last} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0000", {busy, dim_err, mif.c_valid, mif.c_last}); end
    n_tests++; if (mif.c_data !== 16'd0) begin
      n_fail++; $display("FAIL reset_cdata got %0d want 0", mif.c_data); end
    n_tests++; if ({mif.a_rd_row, mif.a_rd_col, mif.b_rd_row, mif.b_rd_col, mif.c_row, mif.c_col} !== 24'd0) begin
      n_fail++; $display("FAIL reset_addr got %h want 0", {mif.a_rd_row, mif.a_rd_col, mif.b_rd_row, mif.b_rd_col, mif.c_row, mif.c_col}); end
    n_tests++; if ({busy8, dim_err8, mif8.c_valid} !== 3'b0) begin
      n_fail++; $display("FAIL reset_dut8 got %b want 000", {busy8, dim_err8, mif8.c_valid}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    elem_t e;
    clear_mem();
    mem_a[0][0] = 4'd1; mem_a[1][1] = 4'd1;
    mem_b[0][0] = 4'd1; mem_b[0][1] = 4'd2; mem_b[1][0] = 4'd3; mem_b[1][1] = 4'd4;
    model(2, 2, 2);
    mif.c_ready = 1'b1;
    do_start(2, 2, 2, 2, 1'b0);
    collect(4, 100);
    n_tests++; if (got_q.size() != 4) begin
      n_fail++; $display("FAIL ident_count got %0d want 4", got_q.size()); end
    for (int n = 0; n < got_q.size() && exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      n_tests++; if (got_q[n] !== e) begin
        n_fail++; $display("FAIL ident_elem%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", n,
                           got_q[n].data, got_q[n].row, got_q[n].col, got_q[n].last, e.data, e.row, e.col, e.last); end
    end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL ident_idle busy got %b want 0", busy); end
  endtask

  task automatic test_full_scale();
    elem_t e;
    fill_mem(2, 3, 2, 15, 15);
    model(2, 3, 2);
    mif.c_ready = 1'b1;
    do_start(2, 3, 3, 2, 1'b0);
    collect(4, 100);
    n_tests++; if (got_q.size() != 4) begin
      n_fail++; $display("FAIL full_count got %0d want 4", got_q.size()); end
    for (int n = 0; n < got_q.size() && exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      n_tests++; if (got_q[n] !== e || e.data !== 16'd675) begin
        n_fail++; $display("FAIL full_elem%0d got d=%0d r=%0d c=%0d l=%b want d=675 r=%0d c=%0d l=%b", n,
                           got_q[n].data, got_q[n].row, got_q[n].col, got_q[n].last, e.row, e.col, e.last); end
    end
    if (got_t.size() == 4) begin
      n_tests++; if (got_t[0] != 5) begin
        n_fail++; $display("FAIL full_latency got %0d want 5", got_t[0]); end
      for (int n = 1; n < 4; n++) begin
        n_tests++; if (got_t[n] - got_t[n-1] != 5) begin
          n_fail++; $display("FAIL full_gap%0d got %0d want 5", n, got_t[n] - got_t[n-1]); end
      end
    end
  endtask

  task automatic test_dim_err();
    int cases [3][4] = '{'{2, 2, 3, 2}, '{1, 0, 0, 1}, '{4, 1, 1, 1}};
    int vld;
    mif.c_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      do_start(cases[t][0], cases[t][1], cases[t][2], cases[t][3], 1'b0);
      n_tests++; if ({dim_err, busy} !== 2'b11) begin
        n_fail++; $display("FAIL dimerr%0d_pulse got err,busy=%b want 11", t, {dim_err, busy}); end
      @(negedge clk);
      n_tests++; if ({dim_err, busy} !== 2'b00) begin
        n_fail++; $display("FAIL dimerr%0d_after got err,busy=%b want 00", t, {dim_err, busy}); end
      vld = 0;
      repeat (8) begin
        @(negedge clk);
        if (mif.c_valid) vld++;
      end
      n_tests++; if (vld != 0) begin
        n_fail++; $display("FAIL dimerr%0d_novalid got %0d valid cycles want 0", t, vld); end
    end
  endtask

  task automatic test_backpressure();
    elem_t o, e;
    int w;
    clear_mem();
    mem_a[0][0] = 4'd1; mem_a[1][1] = 4'd1;
    mem_b[0][0] = 4'd1; mem_b[0][1] = 4'd2; mem_b[1][0] = 4'd3; mem_b[1][1] = 4'd4;
    model(2, 2, 2);
    mif.c_ready = 1'b0;
    do_start(2, 2, 2, 2, 1'b0);
    w = 0;
    while (!mif.c_valid && w < 50) begin @(negedge clk); w++; end
    n_tests++; if (mif.c_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_wait c_valid got %b want 1", mif.c_valid); end
    e = exp_q.pop_front();
    for (int h = 0; h < 5; h++) begin
      o = {mif.c_data, mif.c_row, mif.c_col, mif.c_last};
      n_tests++; if (mif.c_valid !== 1'b1 || o !== e) begin
        n_fail++; $display("FAIL bp_hold%0d got v=%b d=%0d r=%0d c=%0d want v=1 d=%0d r=%0d c=%0d", h,
                           mif.c_valid, o.data, o.row, o.col, e.data, e.row, e.col); end
      @(negedge clk);
    end
    mif.c_ready = 1'b1;
    @(negedge clk);
    n_tests++; if ({mif.c_valid, busy} !== 2'b01) begin
      n_fail++; $display("FAIL bp_drop got valid,busy=%b want 01", {mif.c_valid, busy}); end
    collect(3, 100);
    n_tests++; if (got_q.size() != 3) begin
      n_fail++; $display("FAIL bp_count got %0d want 3", got_q.size()); end
    for (int n = 0; n < got_q.size() && exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      n_tests++; if (got_q[n] !== e) begin
        n_fail++; $display("FAIL bp_elem%0d got d=%0d r=%0d c=%0d want d=%0d r=%0d c=%0d", n,
                           got_q[n].data, got_q[n].row, got_q[n].col, e.data, e.row, e.col); end
    end
  endtask

  task automatic test_reset_mid();
    elem_t e;
    clear_mem();
    mem_a[0][0] = 4'd1; mem_a[0][1] = 4'd2; mem_a[0][2] = 4'd3;
    mem_a[1][0] = 4'd4; mem_a[1][1] = 4'd5; mem_a[1][2] = 4'd6;
    mem_b[0][0] = 4'd7; mem_b[0][1] = 4'd8; mem_b[1][0] = 4'd9;
    mem_b[1][1] = 4'd10; mem_b[2][0] = 4'd11; mem_b[2][1] = 4'd12;
    mif.c_ready = 1'b1;
    do_start(2, 3, 3, 2, 1'b0);
    collect(2, 100);
    repeat (2) @(negedge clk);
    n_tests++; if ({busy, mif.c_valid, mif.c_row, mif.c_col} !== {2'b10, 4'd1, 4'd0}) begin
      n_fail++; $display("FAIL rstmid_pre got busy=%b v=%b r=%0d c=%0d want busy=1 v=0 r=1 c=0",
                         busy, mif.c_valid, mif.c_row, mif.c_col); end
    rst = 1'b1;
    #1;
    n_tests++; if ({busy, dim_err, mif.c_valid, mif.c_last, mif.c_data} !== 20'd0) begin
      n_fail++; $display("FAIL rstmid_ctrl got %h want 0", {busy, dim_err, mif.c_valid, mif.c_last, mif.c_data}); end
    n_tests++; if ({mif.a_rd_row, mif.a_rd_col, mif.b_rd_row, mif.b_rd_col, mif.c_row, mif.c_col} !== 24'd0) begin
      n_fail++; $display("FAIL rstmid_addr got %h want 0", {mif.a_rd_row, mif.a_rd_col, mif.b_rd_row, mif.b_rd_col, mif.c_row, mif.c_col}); end
    @(negedge clk);
    rst = 1'b0;
    model(2, 3, 2);
    do_start(2, 3, 3, 2, 1'b0);
    collect(4, 100);
    n_tests++; if (got_q.size() != 4) begin
      n_fail++; $display("FAIL rstmid_count got %0d want 4", got_q.size()); end
    for (int n = 0; n < got_q.size() && exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      n_tests++; if (got_q[n] !== e) begin
        n_fail++; $display("FAIL rstmid_elem%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", n,
                           got_q[n].data, got_q[n].row, got_q[n].col, got_q[n].last, e.data, e.row, e.col, e.last); end
    end
  endtask

  task automatic test_acc_wrap();
    logic [7:0] want;
    int cyc, got;
`ifdef ACC_SAT_EN
    want = 8'd255;
`else
    want = 8'd163;
`endif
    fill_mem(2, 3, 2, 15, 15);
    mif8.c_ready = 1'b1;
    do_start(2, 3, 3, 2, 1'b1);
    cyc = 0; got = 0;
    while (got < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mif8.c_valid && mif8.c_ready) begin
        n_tests++; if ({mif8.c_data, mif8.c_row, mif8.c_col, mif8.c_last} !== {want, 4'(got / 2), 4'(got % 2), (got == 3)}) begin
          n_fail++; $display("FAIL acc8_elem%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", got,
                             mif8.c_data, mif8.c_row, mif8.c_col, mif8.c_last, want, got / 2, got % 2, got == 3); end
        got++;
      end
    end
    n_tests++; if (got != 4) begin
      n_fail++; $display("FAIL acc8_count got %0d want 4", got); end
    @(negedge clk);
    n_tests++; if ({busy8, dim_err8} !== 2'b00) begin
      n_fail++; $display("FAIL acc8_idle got busy,err=%b want 00", {busy8, dim_err8}); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_full_scale();
    test_dim_err();
    test_backpressure();
    test_reset_mid();
    test_acc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
